crc_tx_arbiter: RTL
===================

CRC_TX_ARBITER -- requirements
Module: crc_tx_arbiter

Interface
REQ-001 SHALL have port clk  in  1  sole clock; all state changes on posedge clk.
REQ-002 SHALL have port rst_L  in  1  reset; one clock, reset is synchronous and active-low (sampled on posedge clk).
REQ-003 SHALL have ports tok_req in 1 (token send request), tok_data in 11 (token field, CRC5 covered), tok_gnt out 1, tok_done out 1 (one-cycle pulse).
REQ-004 SHALL have ports dat_req in 1, dat_valid in 1, dat_bit in 1, dat_last in 1 (serial data stream, CRC16 covered), dat_ready out 1, dat_gnt out 1, dat_done out 1 (pulse).
REQ-005 SHALL have ports tx_pause in 1: downstream stall.
REQ-006 SHALL have encoder-side outputs crc_inb, crc_recving, crc_pkttype (1 = CRC16, 0 = CRC5), crc_start and crc_pause_out, each 1 bit.
REQ-007 SHALL have encoder-side input crc_sending in 1.
REQ-008 SHALL have output drain_err out 1: sticky drain-timeout flag.

Function
REQ-009 SHALL implement the states IDLE, START, STREAM, DRAIN and DONE.
REQ-010 IDLE: when any request is high, SHALL grant one requester and go to START next cycle. The grant is latched in a register and held until DONE.
REQ-011 Arbitration SHALL be round-robin: when both request, the one not granted last wins. After reset, token wins the first tie.
REQ-012 START, one cycle: crc_start=1, crc_recving=1, crc_pkttype=0 for token or 1 for data, crc_inb=0; SHALL consume no data; tok_data SHALL be loaded into an 11-bit shift register and the bit counter cleared.
REQ-013 STREAM (token): crc_inb=shift[0], LSB first. On each cycle with tx_pause=0 the block SHALL shift right and increment a 4-bit count. After the 11th accepted bit (count 10 accepted) it SHALL go to DRAIN.
REQ-014 STREAM (data): dat_ready = ~tx_pause; crc_inb=dat_bit. A bit SHALL be accepted when dat_valid & dat_ready. Acceptance with dat_last=1 SHALL go to DRAIN.
REQ-015 Underrun: in STREAM with data granted and dat_valid=0, the block SHALL stay in STREAM with crc_recving=1.
REQ-016 crc_pause_out SHALL equal tx_pause, OR-ed with underrun (REQ-015).
REQ-017 crc_recving SHALL be 1 in START and STREAM and 0 otherwise. crc_pkttype SHALL be held stable from START through DRAIN.
REQ-018 DRAIN: recving=0, and a 5-bit drain counter SHALL increment each cycle. The block SHALL go to DONE when crc_sending=0 is sampled in DRAIN, but no earlier than the 2nd DRAIN cycle.
REQ-019 If the drain counter reaches 24 before REQ-018 exit, the block SHALL set drain_err=1 and go to DONE.
REQ-020 DONE, one cycle: the block SHALL pulse the granted requester's *_done, drop its *_gnt, record last-granted and return to IDLE. A new grant is therefore possible no sooner than the cycle after DONE.
REQ-021 tok_gnt/dat_gnt SHALL be high from START through DONE inclusive and never both high. tok_req/dat_req changes after grant SHALL be ignored until IDLE.
REQ-022 dat_ready SHALL be 0 outside STREAM-with-data-grant. tok_data SHALL be sampled only in IDLE→START.
REQ-023 Simultaneous: a request arriving in the DONE cycle SHALL be serviced only from the following IDLE cycle. tx_pause during DRAIN SHALL not stop the drain counter.

Reset
REQ-024 With rst_L=0 at posedge, the block SHALL go to IDLE, and all outputs SHALL be 0: gnts, dones, dat_ready, crc_*, drain_err.
REQ-025 With rst_L=0 at posedge, the last-granted register SHALL be set to data, so that token wins the first tie.
REQ-026 Reset mid-STREAM or mid-DRAIN SHALL abort with no *_done pulse. Reset is the only way to clear drain_err.

Verification
REQ-027 Bench SHALL cover a token alone: tok_data=11'h5A3 with tx_pause=0 -> crc_start for 1 cycle, then crc_inb sequence 1,1,0,0,0,1,0,1,1,0,1 over 11 cycles, then recving=0; model crc_sending high for 5 cycles -> tok_done pulse 1 cycle later.
REQ-028 Bench SHALL cover tok_req and dat_req raised in the same cycle after reset -> token granted first; dat_gnt asserted in the START cycle following token DONE+IDLE.
REQ-029 Bench SHALL cover a data packet of 8 bits with dat_valid low for 3 cycles mid-stream -> crc_pause_out=1 for exactly those 3 cycles, recving stays 1, and exactly 8 bits are accepted.
REQ-030 Bench SHALL cover tx_pause=1 for 4 cycles during token STREAM -> shift and count frozen, crc_pause_out=1, and 11 bits still delivered in order.
REQ-031 Bench SHALL cover crc_sending held 1 forever in DRAIN -> drain_err=1 after 24 DRAIN cycles, done pulse, return to IDLE; drain_err persists until rst_L=0.
REQ-032 Bench SHALL cover rst_L=0 during STREAM -> next cycle all outputs 0, no done pulse.

Source files
------------

// File: rtl/crc_tx_arbiter.sv
// Purpose: round-robin arbiter feeding one token (CRC5) or serial data (CRC16) packet into a CRC encoder.
// Latency: grant decided in IDLE, START one cycle later, one bit per accepted STREAM cycle, DRAIN >= 2 cycles, DONE 1 cycle.
// Backpressure: tx_pause freezes the token shifter and deasserts dat_ready; data underrun is forwarded as crc_pause_out.
module crc_tx_arbiter (
  input  logic        clk,
  input  logic        rst_L,
  input  logic        tok_req,
  input  logic [10:0] tok_data,
  output logic        tok_gnt,
  output logic        tok_done,
  input  logic        dat_req,
  input  logic        dat_valid,
  input  logic        dat_bit,
  input  logic        dat_last,
  output logic        dat_ready,
  output logic        dat_gnt,
  output logic        dat_done,
  input  logic        tx_pause,
  output logic        crc_inb,
  output logic        crc_recving,
  output logic        crc_pkttype,
  output logic        crc_start,
  output logic        crc_pause_out,
  input  logic        crc_sending,
  output logic        drain_err
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_STREAM = 3'd2,
    S_DRAIN  = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  // Drain gives up after this many cycles with the encoder still busy.
  localparam logic [4:0] DRAIN_LIMIT = 5'd24;
  // Index of the final token bit (11 bits, counted from zero).
  localparam logic [3:0] TOK_LAST_IDX = 4'd10;

  state_t      state_q, state_d;
  logic        gnt_tok_q, gnt_tok_d;     // 1: token owns the encoder, 0: data
  logic        last_tok_q, last_tok_d;   // 1: token was granted most recently
  logic [10:0] shift_q, shift_d;
  logic [3:0]  bit_cnt_q, bit_cnt_d;
  logic [4:0]  drain_cnt_q, drain_cnt_d;
  logic        drain_err_q, drain_err_d;

  logic        busy;
  logic        strm_dat;
  logic        underrun;

  // State and datapath registers, synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_L) begin
      state_q     <= S_IDLE;
      gnt_tok_q   <= 1'b0;
      last_tok_q  <= 1'b0;
      shift_q     <= '0;
      bit_cnt_q   <= '0;
      drain_cnt_q <= '0;
      drain_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      gnt_tok_q   <= gnt_tok_d;
      last_tok_q  <= last_tok_d;
      shift_q     <= shift_d;
      bit_cnt_q   <= bit_cnt_d;
      drain_cnt_q <= drain_cnt_d;
      drain_err_q <= drain_err_d;
    end
  end

  // Next-state: arbitration, bit streaming and drain supervision.
  always_comb begin
    state_d     = state_q;
    gnt_tok_d   = gnt_tok_q;
    last_tok_d  = last_tok_q;
    shift_d     = shift_q;
    bit_cnt_d   = bit_cnt_q;
    drain_cnt_d = drain_cnt_q;
    drain_err_d = drain_err_q;

    case (state_q)
      S_IDLE: begin
        if (tok_req || dat_req) begin
          // On a tie the side that did not win last time takes the grant.
          gnt_tok_d = (tok_req && dat_req) ? ~last_tok_q : tok_req;
          shift_d   = tok_data;
          bit_cnt_d = '0;
          state_d   = S_START;
        end
      end

      S_START: begin
        state_d = S_STREAM;
      end

      S_STREAM: begin
        if (gnt_tok_q) begin
          if (!tx_pause) begin
            shift_d   = {1'b0, shift_q[10:1]};
            bit_cnt_d = bit_cnt_q + 4'd1;
            if (bit_cnt_q == TOK_LAST_IDX) begin
              drain_cnt_d = '0;
              state_d     = S_DRAIN;
            end
          end
        end else if (dat_valid && !tx_pause && dat_last) begin
          drain_cnt_d = '0;
          state_d     = S_DRAIN;
        end
      end

      S_DRAIN: begin
        // Counts regardless of tx_pause; normal exit takes priority over timeout.
        drain_cnt_d = drain_cnt_q + 5'd1;
        if ((drain_cnt_q != 5'd0) && !crc_sending) begin
          state_d = S_DONE;
        end else if (drain_cnt_d == DRAIN_LIMIT) begin
          drain_err_d = 1'b1;
          state_d     = S_DONE;
        end
      end

      S_DONE: begin
        last_tok_d = gnt_tok_q;
        state_d    = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Outputs decoded from the current state and the latched grant.
  always_comb begin
    busy     = (state_q != S_IDLE);
    strm_dat = (state_q == S_STREAM) && !gnt_tok_q;
    underrun = strm_dat && !dat_valid;

    tok_gnt     = busy && gnt_tok_q;
    dat_gnt     = busy && !gnt_tok_q;
    tok_done    = (state_q == S_DONE) && gnt_tok_q;
    dat_done    = (state_q == S_DONE) && !gnt_tok_q;

    crc_start   = (state_q == S_START);
    crc_recving = (state_q == S_START) || (state_q == S_STREAM);
    crc_pkttype = !gnt_tok_q &&
                  ((state_q == S_START) || (state_q == S_STREAM) || (state_q == S_DRAIN));
    crc_inb     = (state_q == S_STREAM) && (gnt_tok_q ? shift_q[0] : dat_bit);

    dat_ready     = strm_dat && !tx_pause;
    crc_pause_out = busy && (state_q != S_DONE) && (tx_pause || underrun);
    drain_err     = drain_err_q;
  end

endmodule
